// File: rtl/beta_pkg.sv
// Shared state encoding for the Beta step controller.
package beta_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_HALT = 2'b11
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop sync -> stable-level filter; btn_press is a 1-cycle strobe on an accepted rising level.
// Latency: sync (2) + DEBOUNCE_CYCLES stable samples; no backpressure.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DB_W            = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press
);

  localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync_a;
  logic            sync_b;
  logic [DB_W-1:0] cnt;
  logic            settle;

  // Press fires in the same cycle the new level is committed, so it can never repeat.
  assign settle    = (sync_b != btn_level) && (cnt == CNT_MAX);
  assign btn_press = settle & sync_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a    <= 1'b0;
      sync_b    <= 1'b0;
      btn_level <= 1'b0;
      cnt       <= '0;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
      if (sync_b == btn_level) begin
        cnt <= '0;
      end else if (settle) begin
        btn_level <= sync_b;
        cnt       <= '0;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/beta_step_ctrl.sv
// Turns slow_clk_in rising edges into single-cycle cpu_en pulses under run/step/halt control.
// Latency: slow_clk_in rise -> cpu_en one clk later; no backpressure, halt_req wins over everything.
import beta_pkg::*;

module beta_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DB_W            = 20,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slow_clk_in,
  input  logic             btn_run,
  input  logic             btn_step,
  input  logic             halt_req,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic             running,
  output logic [CNT_W-1:0] step_count
);

  state_t st;
  logic   slow_q;
  logic   tick;
  logic   run_press;
  logic   step_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_run_db (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_run),
    .btn_level (),
    .btn_press (run_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_step_db (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_step),
    .btn_level (),
    .btn_press (step_press)
  );

  // slow_q resets high so a divider already sitting at 1 does not produce a tick.
  assign tick  = slow_clk_in & ~slow_q;
  assign state = st;

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= ST_IDLE;
      cpu_en     <= 1'b0;
      running    <= 1'b0;
      step_count <= '0;
      slow_q     <= 1'b1;
    end else begin
      slow_q <= slow_clk_in;
      cpu_en <= 1'b0;
      if (halt_req) begin
        st      <= ST_HALT;
        running <= 1'b0;
      end else begin
        case (st)
          ST_IDLE: begin
            if (run_press) begin
              st      <= ST_RUN;
              running <= 1'b1;
            end else if (step_press) begin
              st <= ST_STEP;
            end
          end
          ST_RUN: begin
            if (run_press) begin
              st      <= ST_IDLE;
              running <= 1'b0;
            end else if (tick) begin
              cpu_en     <= 1'b1;
              step_count <= step_count + CNT_W'(1);
            end
          end
          ST_STEP: begin
            if (tick) begin
              cpu_en     <= 1'b1;
              step_count <= step_count + CNT_W'(1);
              st         <= ST_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_beta_step_ctrl.sv
// Randomized bench for beta_step_ctrl against a rule-level reference model.
module tb_beta_step_ctrl;
  import beta_pkg::*;

  localparam int DB = 4;
  localparam int DBW = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, slow_clk_in, btn_run, btn_step, halt_req;
  logic          cpu_en, running;
  logic [1:0]    state;
  logic [CW-1:0] step_count;

  int checks = 0;
  int failures = 0;
  int phase = 0;

  // reference model state
  state_t        m_state;
  logic          m_cpu_en, m_running, m_slow_q;
  logic [CW-1:0] m_count;
  logic [1:0]    m_sr, m_ss;
  logic          m_lvl_r, m_lvl_s;
  logic [DB-1:0] m_hist_r, m_hist_s;

  beta_step_ctrl #(.DEBOUNCE_CYCLES(DB), .DB_W(DBW), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .slow_clk_in (slow_clk_in),
    .btn_run     (btn_run),
    .btn_step    (btn_step),
    .halt_req    (halt_req),
    .cpu_en      (cpu_en),
    .state       (state),
    .running     (running),
    .step_count  (step_count)
  );

  always #5 clk = ~clk;

  // A button is accepted once its last DB synchronised samples all disagree with the current level.
  task automatic model_step();
    logic tick, rp, sp, pulse;
    state_t nxt;
    if (rst) begin
      m_state = ST_IDLE; m_cpu_en = 1'b0; m_running = 1'b0; m_count = '0; m_slow_q = 1'b1;
      m_sr = '0; m_ss = '0; m_lvl_r = 1'b0; m_lvl_s = 1'b0; m_hist_r = '0; m_hist_s = '0;
      return;
    end
    m_hist_r = {m_hist_r[DB-2:0], m_sr[1]};
    m_hist_s = {m_hist_s[DB-2:0], m_ss[1]};
    rp = !m_lvl_r && (&m_hist_r);
    sp = !m_lvl_s && (&m_hist_s);
    if (&m_hist_r) m_lvl_r = 1'b1; else if (~|m_hist_r) m_lvl_r = 1'b0;
    if (&m_hist_s) m_lvl_s = 1'b1; else if (~|m_hist_s) m_lvl_s = 1'b0;
    m_sr = {m_sr[0], btn_run};
    m_ss = {m_ss[0], btn_step};
    tick = slow_clk_in && !m_slow_q;
    m_slow_q = slow_clk_in;
    pulse = 1'b0;
    nxt = m_state;
    if (halt_req) nxt = ST_HALT;
    else if (m_state == ST_IDLE) begin
      if (rp) nxt = ST_RUN; else if (sp) nxt = ST_STEP;
    end else if (m_state == ST_RUN) begin
      if (rp) nxt = ST_IDLE; else if (tick) pulse = 1'b1;
    end else if (m_state == ST_STEP && tick) begin
      pulse = 1'b1; nxt = ST_IDLE;
    end
    m_state = nxt;
    m_cpu_en = pulse;
    m_running = (nxt == ST_RUN);
    m_count = m_count + CW'(pulse);
  endtask

  // slow_clk_in: 8-cycle period, 50% duty; phase holds the slot about to be applied
  task automatic cyc();
    slow_clk_in = (phase >= 4);
    phase = (phase + 1) % 8;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; btn_run = 1'b0; btn_step = 1'b0; halt_req = 1'b0;
    phase = $urandom_range(0, 7);
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    phase = 4; rst = 1'b1; btn_run = 1'b0; btn_step = 1'b0; halt_req = 1'b0;
    repeat (3) cyc();
    checks++;
    if (cpu_en !== 1'b0 || state !== 2'b00 || running !== 1'b0 || step_count !== 4'h0) begin
      failures++;
      $display("FAIL reset_values: got en=%b st=%b run=%b cnt=%0d expected 0/00/0/0", cpu_en, state, running, step_count);
    end
    rst = 1'b0;
    cyc();
    checks++;
    if (cpu_en !== 1'b0) begin
      failures++; $display("FAIL reset_no_false_edge: cpu_en=%b expected 0", cpu_en);
    end
    checks++;
    if (state !== m_state || step_count !== m_count) begin
      failures++; $display("FAIL reset_model: st=%b cnt=%0d expected st=%b cnt=%0d", state, step_count, m_state, m_count);
    end
  endtask

  task automatic test_run();
    int pulses, exp_pulses, first_run;
    pulses = 0; exp_pulses = 0; first_run = -1;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      btn_run = (i < 10);
      cyc();
      checks++;
      if (cpu_en !== m_cpu_en || state !== m_state || running !== m_running || step_count !== m_count) begin
        failures++;
        $display("FAIL run_cycle%0d: got en=%b st=%b run=%b cnt=%0d expected en=%b st=%b run=%b cnt=%0d",
                 i, cpu_en, state, running, step_count, m_cpu_en, m_state, m_running, m_count);
      end
      if (cpu_en === 1'b1) pulses++;
      if (m_cpu_en) exp_pulses++;
      if (state === 2'b01 && first_run < 0) first_run = i;
    end
    btn_run = 1'b0;
    checks++;
    if (first_run < 4 || first_run > 8) begin
      failures++; $display("FAIL run_latency: entered RUN at cycle %0d expected 4..8", first_run);
    end
    checks++;
    if (pulses != exp_pulses || pulses < 5) begin
      failures++; $display("FAIL run_pulses: got %0d expected %0d (at least 5)", pulses, exp_pulses);
    end
  endtask

  task automatic test_bounce();
    int per, seen_en;
    seen_en = 0;
    do_reset();
    per = $urandom_range(1, 3);
    for (int i = 0; i < 30; i++) begin
      btn_run = (i < 20) && (((i / per) % 2) == 0);
      cyc();
      if (cpu_en !== 1'b0) seen_en++;
      checks++;
      if (state !== 2'b00 || state !== m_state || cpu_en !== m_cpu_en) begin
        failures++;
        $display("FAIL bounce_cycle%0d: got st=%b en=%b expected st=00 en=0 (model st=%b)", i, state, cpu_en, m_state);
      end
    end
    btn_run = 1'b0;
    checks++;
    if (seen_en != 0) begin
      failures++; $display("FAIL bounce_cpu_en: saw %0d pulses expected 0", seen_en);
    end
  endtask

  task automatic test_step();
    int h, pulses, saw_step;
    pulses = 0; saw_step = 0;
    do_reset();
    h = $urandom_range(8, 12);
    for (int i = 0; i < 40; i++) begin
      btn_step = (i < h);
      cyc();
      checks++;
      if (cpu_en !== m_cpu_en || state !== m_state || running !== m_running || step_count !== m_count) begin
        failures++;
        $display("FAIL step_cycle%0d: got en=%b st=%b cnt=%0d expected en=%b st=%b cnt=%0d",
                 i, cpu_en, state, step_count, m_cpu_en, m_state, m_count);
      end
      if (cpu_en === 1'b1) pulses++;
      if (state === 2'b10) saw_step = 1;
    end
    btn_step = 1'b0;
    checks++;
    if (pulses != 1 || saw_step != 1 || state !== 2'b00 || step_count !== 4'h1) begin
      failures++;
      $display("FAIL step_single: pulses=%0d saw_step=%0d st=%b cnt=%0d expected 1/1/00/1", pulses, saw_step, state, step_count);
    end
  endtask

  task automatic test_both();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      btn_run = (i < 8); btn_step = (i < 8);
      cyc();
      checks++;
      if (state !== m_state || cpu_en !== m_cpu_en) begin
        failures++; $display("FAIL both_cycle%0d: st=%b en=%b expected st=%b en=%b", i, state, cpu_en, m_state, m_cpu_en);
      end
    end
    btn_run = 1'b0; btn_step = 1'b0;
    checks++;
    if (state !== 2'b01) begin
      failures++; $display("FAIL both_priority: st=%b expected 01", state);
    end
  endtask

  task automatic test_halt();
    logic [CW-1:0] cnt_before;
    int g;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      btn_run = (i < 8);
      cyc();
      checks++;
      if (state !== m_state || cpu_en !== m_cpu_en || step_count !== m_count) begin
        failures++; $display("FAIL halt_prerun%0d: st=%b en=%b expected st=%b en=%b", i, state, cpu_en, m_state, m_cpu_en);
      end
    end
    btn_run = 1'b0;
    g = 0;
    while (phase != 4 && g < 16) begin cyc(); g++; end
    cnt_before = m_count;
    halt_req = 1'b1;
    cyc();
    checks++;
    if (cpu_en !== 1'b0 || state !== 2'b11 || running !== 1'b0) begin
      failures++; $display("FAIL halt_enter: en=%b st=%b run=%b expected 0/11/0", cpu_en, state, running);
    end
    halt_req = 1'b0;
    cyc();
    checks++;
    if (cpu_en !== 1'b0 || step_count !== cnt_before) begin
      failures++; $display("FAIL halt_no_pulse: en=%b cnt=%0d expected 0/%0d", cpu_en, step_count, cnt_before);
    end
    for (int i = 0; i < 24; i++) begin
      btn_run = (i < 8); btn_step = (i < 8);
      cyc();
      checks++;
      if (state !== 2'b11 || cpu_en !== 1'b0 || state !== m_state) begin
        failures++; $display("FAIL halt_sticky%0d: st=%b en=%b expected 11/0", i, state, cpu_en);
      end
    end
    btn_run = 1'b0; btn_step = 1'b0;
    rst = 1'b1; cyc(); rst = 1'b0;
    checks++;
    if (state !== 2'b00 || step_count !== 4'h0) begin
      failures++; $display("FAIL halt_exit_rst: st=%b cnt=%0d expected 00/0", state, step_count);
    end
  endtask

  task automatic test_wrap();
    int mp, en_after;
    mp = 0; en_after = 0;
    do_reset();
    for (int i = 0; i < 200 && mp < 16; i++) begin
      btn_run = (i < 8);
      cyc();
      if (m_cpu_en) mp++;
      checks++;
      if (cpu_en !== m_cpu_en || step_count !== m_count || running !== m_running) begin
        failures++; $display("FAIL wrap_cycle%0d: en=%b cnt=%0d expected en=%b cnt=%0d", i, cpu_en, step_count, m_cpu_en, m_count);
      end
    end
    btn_run = 1'b0;
    checks++;
    if (mp != 16 || step_count !== 4'h0) begin
      failures++; $display("FAIL wrap_to_zero: ticks=%0d cnt=%0d expected 16/0", mp, step_count);
    end
    for (int i = 0; i < 40; i++) begin
      btn_run = (i < 8);
      cyc();
      if (i >= 8 && cpu_en !== 1'b0) en_after++;
      checks++;
      if (state !== m_state || cpu_en !== m_cpu_en) begin
        failures++; $display("FAIL pause_cycle%0d: st=%b en=%b expected st=%b en=%b", i, state, cpu_en, m_state, m_cpu_en);
      end
    end
    btn_run = 1'b0;
    checks++;
    if (state !== 2'b00 || running !== 1'b0 || en_after != 0) begin
      failures++; $display("FAIL pause_stop: st=%b run=%b late_pulses=%0d expected 00/0/0", state, running, en_after);
    end
  endtask

  task automatic test_random();
    int act, h;
    bit do_step;
    do_reset();
    for (int b = 0; b < 30; b++) begin
      act = $urandom_range(0, 9);
      h = $urandom_range(1, 10);
      do_step = (act >= 4 && act < 7 && m_state == ST_IDLE);
      for (int i = 0; i < 16; i++) begin
        btn_run  = (act < 4) && (i < h);
        btn_step = do_step && (i < h);
        rst      = (act == 9) && (i == 3);
        cyc();
        checks++;
        if (cpu_en !== m_cpu_en || state !== m_state || running !== m_running || step_count !== m_count) begin
          failures++;
          $display("FAIL random_b%0d_c%0d: got en=%b st=%b run=%b cnt=%0d expected en=%b st=%b run=%b cnt=%0d",
                   b, i, cpu_en, state, running, step_count, m_cpu_en, m_state, m_running, m_count);
        end
      end
    end
    rst = 1'b0; btn_run = 1'b0; btn_step = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; btn_run = 1'b0; btn_step = 1'b0; halt_req = 1'b0; slow_clk_in = 1'b0;
    test_reset();
    test_run();
    test_bounce();
    test_step();
    test_both();
    test_halt();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
